// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with CPU register interface and a two-state interrupt
// request FSM. All state updates on the falling edge of clk; rst is async.
//
// Handshake: receive_flag is edge-detected, so a single-cycle pulse or a
// level held high for many cycles both count as exactly one byte. The CPU
// pops with a read strobe at address 253 and acknowledges/clears overflow
// with a write strobe at address 252; write data is not used.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          receive_flag,
  input  logic [7:0]    access_addr,
  input  logic          reg_w_en,
  input  logic          reg_r_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          int_req,
  output logic          state_dbg
);

  localparam logic [7:0]  ADDR_ACK = 8'd252;
  localparam logic [7:0]  ADDR_RD  = 8'd253;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  // rf_q holds receive_flag from the previous falling edge
  logic          rf_q, rf_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q;
  logic          int_req_q;
  logic [7:0]    mem [DEPTH];

  logic push_req, pop, ack, push_ok, drop, empty_w, full_w;

  // Decode strobes and compute next-state values for the FIFO datapath
  always_comb begin
    empty_w  = (count_q == '0);
    full_w   = (count_q == DEPTH_C);
    push_req = receive_flag & ~rf_q;
    pop      = reg_r_en & (access_addr == ADDR_RD) & ~empty_w;
    ack      = reg_w_en & (access_addr == ADDR_ACK);
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept
    push_ok  = push_req & (~full_w | pop);
    drop     = push_req & full_w & ~pop;

    rf_d   = receive_flag;
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as the clear leaves the flag set
    overflow_d = overflow_q;
    if (ack)  overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
  end

  // Datapath registers
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rf_q       <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are never visible while empty so no reset
  always_ff @(negedge clk) begin
    if (push_ok) mem[wptr_q] <= rx_data;
  end

  // Interrupt FSM; decisions use registered status so an ack always
  // produces at least one low cycle on int_req
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (~empty_w | overflow_q) begin
            state_q   <= PENDING;
            int_req_q <= 1'b1;
          end
        end
        PENDING: begin
          if (ack) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Output drive
  always_comb begin
    rd_data   = empty_w ? 8'h00 : mem[rptr_q];
    count     = count_q;
    empty     = empty_w;
    full      = full_w;
    overflow  = overflow_q;
    int_req   = int_req_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a vector table for the single-byte flow,
// directed multi-edge sequences for wrap/overflow/simultaneous/ack/reset,
// and randomized traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  rx_data;
  logic        receive_flag;
  logic [7:0]  access_addr;
  logic        reg_w_en;
  logic        reg_r_en;
  logic [7:0]  rd_data;
  logic [AW:0] count;
  logic        empty, full, overflow, int_req, state_dbg;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .receive_flag(receive_flag),
    .access_addr(access_addr), .reg_w_en(reg_w_en), .reg_r_en(reg_r_en),
    .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .int_req(int_req), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: byte queue, sticky flag, interrupt pending
  logic [7:0] exp_q[$];
  bit ref_ovf, ref_pend, ref_prev_rf;

  typedef struct {
    logic       rf;
    logic [7:0] data;
    logic [7:0] addr;
    logic       w;
    logic       r;
    int         e_count;
    logic [7:0] e_rd;
    logic       e_empty, e_full, e_ovf, e_int;
  } vec_t;
  vec_t vecs[6];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ref_ovf     = 1'b0;
    ref_pend    = 1'b0;
    ref_prev_rf = 1'b1;
  endtask

  // Advance the model by one falling edge with the given inputs
  task automatic model_edge(input logic rf, input logic [7:0] data, input logic [7:0] addr,
                            input logic w, input logic r);
    bit push, pop, ack, drop;
    push = rf && !ref_prev_rf;
    pop  = r && (addr == 8'd253) && (exp_q.size() > 0);
    ack  = w && (addr == 8'd252);
    // interrupt decision uses status from before this edge
    if (ref_pend) begin
      if (ack) ref_pend = 1'b0;
    end else if (exp_q.size() > 0 || ref_ovf) begin
      ref_pend = 1'b1;
    end
    drop = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(data);
      else drop = 1'b1;
    end
    if (ack)  ref_ovf = 1'b0;
    if (drop) ref_ovf = 1'b1;
    ref_prev_rf = rf;
  endtask

  task automatic check_model(input string name);
    logic [7:0] e_rd;
    e_rd = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    cmp({name, ".rd_data"},  rd_data,   e_rd);
    cmp({name, ".count"},    count,     exp_q.size());
    cmp({name, ".empty"},    empty,     exp_q.size() == 0);
    cmp({name, ".full"},     full,      exp_q.size() == DEPTH);
    cmp({name, ".overflow"}, overflow,  ref_ovf);
    cmp({name, ".int_req"},  int_req,   ref_pend);
    cmp({name, ".state"},    state_dbg, ref_pend);
  endtask

  task automatic check_reset_values(input string name);
    cmp({name, ".rd_data"},  rd_data,  8'h00);
    cmp({name, ".count"},    count,    0);
    cmp({name, ".empty"},    empty,    1);
    cmp({name, ".full"},     full,     0);
    cmp({name, ".overflow"}, overflow, 0);
    cmp({name, ".int_req"},  int_req,  0);
  endtask

  // Driver: apply inputs for one falling edge, then check against the model
  task automatic apply(input logic rf, input logic [7:0] data, input logic [7:0] addr,
                       input logic w, input logic r, input string name);
    receive_flag = rf;
    rx_data      = data;
    access_addr  = addr;
    reg_w_en     = w;
    reg_r_en     = r;
    model_edge(rf, data, addr, w, r);
    @(negedge clk);
    #1;
    check_model(name);
  endtask

  task automatic push_byte(input logic [7:0] d);
    apply(1'b1, d, 8'd0, 1'b0, 1'b0, "push");
    apply(1'b0, d, 8'd0, 1'b0, 1'b0, "push_low");
  endtask

  task automatic pop_byte(input logic [7:0] e);
    cmp("pop_head", rd_data, e);
    apply(1'b0, 8'h00, 8'd253, 1'b0, 1'b1, "pop");
  endtask

  task automatic ack_write();
    apply(1'b0, 8'h00, 8'd252, 1'b1, 1'b0, "ack");
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'd0,   1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA5, 8'd0,   1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'd0,   1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 8'd253, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 8'd252, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'd0,   1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    receive_flag = 1'b0;
    rx_data = 8'h00;
    access_addr = 8'h00;
    reg_w_en = 1'b0;
    reg_r_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Single byte flow from the vector table
    for (int i = 0; i < 6; i++) begin
      receive_flag = vecs[i].rf;
      rx_data      = vecs[i].data;
      access_addr  = vecs[i].addr;
      reg_w_en     = vecs[i].w;
      reg_r_en     = vecs[i].r;
      model_edge(vecs[i].rf, vecs[i].data, vecs[i].addr, vecs[i].w, vecs[i].r);
      @(negedge clk);
      #1;
      cmp($sformatf("vec%0d.count", i),    count,    vecs[i].e_count);
      cmp($sformatf("vec%0d.rd_data", i),  rd_data,  vecs[i].e_rd);
      cmp($sformatf("vec%0d.empty", i),    empty,    vecs[i].e_empty);
      cmp($sformatf("vec%0d.full", i),     full,     vecs[i].e_full);
      cmp($sformatf("vec%0d.overflow", i), overflow, vecs[i].e_ovf);
      cmp($sformatf("vec%0d.int_req", i),  int_req,  vecs[i].e_int);
    end

    // Fill and wrap
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    cmp("fill.full", full, 1);
    for (int i = 1; i <= 3; i++) pop_byte(8'(i));
    for (int i = 9; i <= 11; i++) push_byte(8'(i));
    cmp("wrap.full", full, 1);
    for (int i = 4; i <= 11; i++) pop_byte(8'(i));
    cmp("wrap.empty", empty, 1);
    ack_write();

    // Overflow: dropped byte is never read
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    push_byte(8'hFF);
    cmp("ovf.overflow", overflow, 1);
    cmp("ovf.count", count, 8);
    for (int i = 0; i < 8; i++) pop_byte(8'h10 + 8'(i));
    cmp("ovf.empty", empty, 1);
    ack_write();
    cmp("ovf.cleared", overflow, 0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    apply(1'b1, 8'h30, 8'd253, 1'b0, 1'b1, "pushpop_full");
    cmp("pushpop_full.count", count, 8);
    cmp("pushpop_full.overflow", overflow, 0);
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "idle");
    for (int i = 1; i < 8; i++) pop_byte(8'h20 + 8'(i));
    pop_byte(8'h30);
    // Simultaneous push and pop while empty
    apply(1'b1, 8'h44, 8'd253, 1'b0, 1'b1, "pushpop_empty");
    cmp("pushpop_empty.count", count, 1);
    cmp("pushpop_empty.rd_data", rd_data, 8'h44);
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "idle");
    pop_byte(8'h44);
    ack_write();
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "idle");

    // Ack with data remaining: int_req drops for one edge then returns
    push_byte(8'h51);
    push_byte(8'h52);
    cmp("ack_rem.int_before", int_req, 1);
    ack_write();
    cmp("ack_rem.int_low", int_req, 0);
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "idle");
    cmp("ack_rem.int_again", int_req, 1);

    // Reset mid-operation with receive_flag held high
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    cmp("rst_mid.count", count, 5);
    receive_flag = 1'b1;
    rx_data = 8'h77;
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_values("rst_async");
    #1;
    rst = 1'b0;
    apply(1'b1, 8'h77, 8'd0, 1'b0, 1'b0, "held_high1");
    apply(1'b1, 8'h78, 8'd0, 1'b0, 1'b0, "held_high2");
    cmp("held_high.count", count, 0);
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "flag_low");
    apply(1'b1, 8'h66, 8'd0, 1'b0, 1'b0, "first_push");
    cmp("first_push.count", count, 1);
    cmp("first_push.rd_data", rd_data, 8'h66);
    apply(1'b1, 8'h67, 8'd0, 1'b0, 1'b0, "held_after");
    cmp("held_after.count", count, 1);
    apply(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "idle");
    pop_byte(8'h66);
    ack_write();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic       rf, w, r;
      logic [7:0] d, a;
      int         sel;
      rf  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      sel = $urandom_range(0, 9);
      w   = 1'b0;
      r   = 1'b0;
      a   = 8'($urandom);
      if (i >= 150 && i < 250 && sel < 6) sel = 9;
      case (sel)
        0, 1, 2: begin a = 8'd253; r = 1'b1; end
        3:       begin a = 8'd252; w = 1'b1; end
        4:       begin a = 8'd253; w = 1'b1; end
        5:       begin a = 8'd252; r = 1'b1; end
        6:       begin r = 1'b1; w = 1'($urandom_range(0, 1)); end
        default: begin end
      endcase
      apply(rf, d, a, w, r, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
